// File: rtl/truth_table_seq.sv
// truth_table_seq: steps {a,b,c} through all 8 vectors and records the external x/y responses.
// Latency: SETTLE+2 cycles per vector, 8*(SETTLE+2) cycles from accepted start to DONE.
// Backpressure: none; start is ignored unless IDLE, abort returns to IDLE from any active state.
//
// Ports: i_clk, i_rst (sync, active-high), i_start, i_abort, i_x_in, i_y_in;
//        o_a/o_b/o_c (stimulus), o_busy, o_done (1-cycle pulse), o_idx, o_x_tab, o_y_tab,
//        o_pass/o_fail (only when TTS_COMPARE_EN is defined).
// Optional feature macro: TTS_COMPARE_EN adds the golden-table comparison and pass/fail ports.
module truth_table_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_x_in,
    input  logic       i_y_in,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_idx,
    output logic [7:0] o_x_tab,
    output logic [7:0] o_y_tab
`ifdef TTS_COMPARE_EN
    ,
    output logic       o_pass,
    output logic       o_fail
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_idx;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_x_tab;
    logic [7:0] r_y_tab;
    logic [7:0] w_x_nxt;
    logic [7:0] w_y_nxt;

    // Tables with the current sample merged in; used both for the write and
    // for the comparison on the final vector so it sees all eight bits.
    always_comb begin
        w_x_nxt        = r_x_tab;
        w_y_nxt        = r_y_tab;
        w_x_nxt[r_idx] = i_x_in;
        w_y_nxt[r_idx] = i_y_in;
    end

`ifdef TTS_COMPARE_EN
    logic r_pass;
    logic r_fail;
    logic w_match;

    assign w_match = (w_x_nxt == 8'hA9) && (w_y_nxt == 8'hC3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (r_state == S_IDLE && i_start && !i_abort) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (r_state == S_SAMPLE && !i_abort && r_idx == 3'd7) begin
            r_pass <= w_match;
            r_fail <= !w_match;
        end
    end

    assign o_pass = r_pass;
    assign o_fail = r_fail;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= 3'd0;
            r_abc   <= 3'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x_tab <= 8'd0;
            r_y_tab <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort beats a simultaneous start
                    if (i_start && !i_abort) begin
                        r_state <= S_APPLY;
                        r_idx   <= 3'd0;
                        r_x_tab <= 8'd0;
                        r_y_tab <= 8'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_APPLY: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abc   <= 3'd0;
                    end else begin
                        r_abc   <= r_idx;
                        r_cnt   <= SETTLE_L;
                        r_state <= (SETTLE_L == 4'd0) ? S_SAMPLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abc   <= 3'd0;
                    end else begin
                        // counter starts at SETTLE, so WAIT lasts SETTLE cycles
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt <= 4'd1) begin
                            r_state <= S_SAMPLE;
                        end
                    end
                end
                S_SAMPLE: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_abc   <= 3'd0;
                    end else begin
                        r_x_tab <= w_x_nxt;
                        r_y_tab <= w_y_nxt;
                        if (r_idx == 3'd7) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_abc   <= 3'd0;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_APPLY;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_abc   <= 3'd0;
                end
            endcase
        end
    end

    assign o_a     = r_abc[2];
    assign o_b     = r_abc[1];
    assign o_c     = r_abc[0];
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_idx   = r_idx;
    assign o_x_tab = r_x_tab;
    assign o_y_tab = r_y_tab;

endmodule

// File: tb/tb_truth_table_seq.sv
// tb_truth_table_seq: drives sweeps into two sequencers (SETTLE=1 and SETTLE=0) with
// an attached x/y logic model; expected tables and done cycles are queued per sweep
// and a negedge monitor per instance pops and compares them.
module tb_truth_table_seq;

    localparam int S1 = 1;
    localparam int S0 = 0;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, abort1 = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // external x/y logic: either the reference formulas or an arbitrary lookup table
    logic       use_formula = 1'b1;
    logic [7:0] ext_x = 8'h00;
    logic [7:0] ext_y = 8'h00;

    logic a1, b1, c1, busy1, done1, x1, y1;
    logic [2:0] idx1;
    logic [7:0] xt1, yt1;
    logic a0, b0, c0, busy0, done0, x0, y0;
    logic [2:0] idx0;
    logic [7:0] xt0, yt0;
`ifdef TTS_COMPARE_EN
    logic pass1, fail1, pass0, fail0;
`endif

    exp_t q1[$];
    exp_t q0[$];
    exp_t m1, m0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign x1 = use_formula ? ((a1 | b1) ^ ~c1) : ext_x[{a1, b1, c1}];
    assign y1 = use_formula ? ((a1 | b1) ^ ~(a1 & b1 & (a1 | b1))) : ext_y[{a1, b1, c1}];
    assign x0 = use_formula ? ((a0 | b0) ^ ~c0) : ext_x[{a0, b0, c0}];
    assign y0 = use_formula ? ((a0 | b0) ^ ~(a0 & b0 & (a0 | b0))) : ext_y[{a0, b0, c0}];

    truth_table_seq #(.SETTLE(S1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1),
        .i_x_in(x1), .i_y_in(y1),
        .o_a(a1), .o_b(b1), .o_c(c1), .o_busy(busy1), .o_done(done1),
        .o_idx(idx1), .o_x_tab(xt1), .o_y_tab(yt1)
`ifdef TTS_COMPARE_EN
        , .o_pass(pass1), .o_fail(fail1)
`endif
    );

    truth_table_seq #(.SETTLE(S0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_abort(abort0),
        .i_x_in(x0), .i_y_in(y0),
        .o_a(a0), .o_b(b0), .o_c(c0), .o_busy(busy0), .o_done(done0),
        .o_idx(idx0), .o_x_tab(xt0), .o_y_tab(yt0)
`ifdef TTS_COMPARE_EN
        , .o_pass(pass0), .o_fail(fail0)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: bit i of each table is the response of the attached logic to vector i.
    task automatic model(output logic [7:0] xt, output logic [7:0] yt);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic va, vb, vc;
            v  = 3'(i);
            va = v[2];
            vb = v[1];
            vc = v[0];
            if (use_formula) begin
                xt[i] = (va | vb) ^ ~vc;
                yt[i] = (va | vb) ^ ~(va & vb & (va | vb));
            end else begin
                xt[i] = ext_x[i];
                yt[i] = ext_y[i];
            end
        end
    endtask

    // Monitors: done must rise exactly on the queued cycle, and never otherwise.
    always @(negedge clk) begin
        logic ed;
        ed = (q1.size() > 0) && (cyc >= q1[0].cyc);
        chk("dut1_done", done1, ed);
        if (ed) begin
            m1 = q1.pop_front();
            chk("dut1_x_tab", xt1, m1.x);
            chk("dut1_y_tab", yt1, m1.y);
            chk("dut1_busy_at_done", busy1, 0);
`ifdef TTS_COMPARE_EN
            chk("dut1_pass", pass1, (m1.x == 8'hA9) && (m1.y == 8'hC3));
            chk("dut1_fail", fail1, !((m1.x == 8'hA9) && (m1.y == 8'hC3)));
`endif
        end
        if (!busy1) chk("dut1_abc_idle", {a1, b1, c1}, 0);
    end

    always @(negedge clk) begin
        logic ed;
        ed = (q0.size() > 0) && (cyc >= q0[0].cyc);
        chk("dut0_done", done0, ed);
        if (ed) begin
            m0 = q0.pop_front();
            chk("dut0_x_tab", xt0, m0.x);
            chk("dut0_y_tab", yt0, m0.y);
`ifdef TTS_COMPARE_EN
            chk("dut0_pass", pass0, (m0.x == 8'hA9) && (m0.y == 8'hC3));
`endif
        end
        if (!busy0) chk("dut0_abc_idle", {a0, b0, c0}, 0);
    end

    // Full sweep; optional re-pulse of start on DUT1 at cycle 'repulse' after acceptance.
    task automatic run_sweep(input bit both, input int repulse);
        exp_t e;
        int   acc;
        model(e.x, e.y);
        @(negedge clk);
        start1 = 1'b1;
        start0 = both;
        acc = cyc + 1;
        e.cyc = acc + 8 * (S1 + 2);
        q1.push_back(e);
        if (both) begin
            e.cyc = acc + 8 * (S0 + 2);
            q0.push_back(e);
        end
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
        while (cyc < acc + 8 * (S1 + 2) + 1) begin
            @(negedge clk);
            start1 = (repulse > 0) && (cyc == acc + repulse - 1);
        end
        start1 = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_abc"}, {a1, b1, c1}, 0);
        chk({tag, "_busy"}, busy1, 0);
        chk({tag, "_done"}, done1, 0);
        chk({tag, "_idx"}, idx1, 0);
        chk({tag, "_x_tab"}, xt1, 0);
        chk({tag, "_y_tab"}, yt1, 0);
`ifdef TTS_COMPARE_EN
        chk({tag, "_pass"}, pass1, 0);
        chk({tag, "_fail"}, fail1, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ex, ey;
        int acc;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // reference logic on both settle settings
        use_formula = 1'b1;
        run_sweep(1'b1, 0);

        // start re-pulsed mid-sweep must be ignored
        run_sweep(1'b0, 5);

        // y stuck at zero
        use_formula = 1'b0;
        ext_x = 8'hA9;
        ext_y = 8'h00;
        run_sweep(1'b1, 0);

        // abort in WAIT of vector 3
        use_formula = 1'b1;
        model(ex, ey);
        @(negedge clk);
        start1 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < acc + 10) @(negedge clk);
        chk("abort_idx_before", idx1, 3);
        chk("abort_abc_in_wait", {a1, b1, c1}, 3);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        chk("abort_busy", busy1, 0);
        chk("abort_abc", {a1, b1, c1}, 0);
        chk("abort_x_tab", xt1, ex & 8'h07);
        chk("abort_y_tab", yt1, ey & 8'h07);

        // abort and start together in IDLE: no start
        @(negedge clk);
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        chk("abort_start_busy", busy1, 0);
        chk("abort_start_x_kept", xt1, ex & 8'h07);
        repeat (30) @(negedge clk);

        // reset during SAMPLE of vector 5
        @(negedge clk);
        start1 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < acc + 17) @(negedge clk);
        chk("rst_idx_before", idx1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midrst");

        // new sweep after reset, then random tables
        run_sweep(1'b1, 0);
        use_formula = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ext_x = (k == 0) ? 8'hA9 : 8'($urandom);
            ext_y = (k == 0) ? 8'hC3 : 8'($urandom);
            run_sweep(1'b1, (k == 3) ? int'($urandom_range(2, 20)) : 0);
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_seq.md
TRUTH_TABLE_SEQ -- requirements
Module: truth_table_seq

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Parameter SETTLE, default 1, range 0..15: wait cycles between driving a/b/c and sampling x_in/y_in.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a full 8-vector sweep; honoured only in IDLE.
REQ-006 abort  input  1  cancel a running sweep.
REQ-007 a, b, c  output  1 each  stimulus to the external x/y logic; {a,b,c} = current vector index.
REQ-008 x_in, y_in  input  1 each  responses from the external x/y logic.
REQ-009 busy  output  1  high in every state except IDLE and DONE.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 idx  output  3  current vector index.
REQ-012 x_tab, y_tab  output  8 each  captured responses; bit i holds the response for {a,b,c}=i.
REQ-013 pass, fail  output  1 each  present only with TTS_COMPARE_EN.

Function
REQ-014 FSM states SHALL be IDLE, APPLY, WAIT, SAMPLE, DONE; all outputs SHALL be registered.
REQ-015 IDLE with start=1 -> APPLY next cycle, with idx=0 and x_tab=y_tab=0 on that same edge.
REQ-016 APPLY SHALL drive {a,b,c}=idx, load the settle counter with SETTLE, and go to WAIT, or to SAMPLE if SETTLE=0.
REQ-017 WAIT SHALL decrement the counter each cycle and go to SAMPLE when the counter reaches 1; a/b/c SHALL hold steady.
REQ-018 SAMPLE SHALL write x_in into x_tab[idx] and y_in into y_tab[idx].
REQ-019 From SAMPLE: if idx=7, go to DONE; otherwise idx increments by 1 (3-bit, no wrap reached) and the FSM goes to APPLY.
REQ-020 Each vector SHALL take SETTLE+2 cycles; a sweep SHALL take 8*(SETTLE+2) cycles from start acceptance to DONE entry.
REQ-021 DONE SHALL assert done for exactly one cycle, then return to IDLE; tables SHALL hold until the next accepted start.
REQ-022 start while busy, or while in DONE, SHALL be ignored.
REQ-023 abort=1 in APPLY, WAIT or SAMPLE -> IDLE next cycle, with no table write that cycle and no done pulse; partial tables are retained.
REQ-024 abort and start together in IDLE: abort wins and the sweep does not start.
REQ-025 a, b, c SHALL be 0 in IDLE and DONE.

Reset
REQ-026 rst=1 SHALL force IDLE, idx=0, a=b=c=0, busy=0, done=0, x_tab=y_tab=0, counter=0, and pass=fail=0 when compiled in.
REQ-027 rst has priority over start and abort, and takes effect mid-sweep on the next edge.

Configuration
REQ-028 Macro TTS_COMPARE_EN SHALL control the pass/fail check.
REQ-029 With TTS_COMPARE_EN defined: on DONE entry, pass=1 iff x_tab==8'hA9 and y_tab==8'hC3, and fail is the inverse.
REQ-030 With TTS_COMPARE_EN defined: pass and fail hold until the next accepted start or rst, which clears both to 0.
REQ-031 Without TTS_COMPARE_EN: the pass/fail ports and the comparison logic SHALL be absent; all other behaviour is identical.

Verification (SETTLE=1 unless noted)
REQ-032 Reference logic x=(a|b)^~c, y=(a|b)^~(a&b&(a|b)) attached, start pulse -> done at cycle 24 after acceptance; x_tab=A9, y_tab=C3; pass=1 with macro.
REQ-033 SETTLE=0, same stimulus -> done after 16 cycles; same tables.
REQ-034 abort asserted in WAIT of idx=3 -> IDLE next cycle, no done; x_tab[2:0]=3'b001, higher bits 0.
REQ-035 start re-pulsed at cycle 5 of a sweep -> ignored; done still arrives at cycle 24.
REQ-036 rst during SAMPLE of idx=5 -> all outputs at reset values next cycle; a new start completes normally.
REQ-037 y_in stuck at 0 -> y_tab=00 and fail=1 with macro.
